// File: rtl/vec_store_pkg.sv
// Shared types and default sizes for the vector store path.
package vec_store_pkg;

    // Default widths of the image/vector RAM write port
    localparam int DEF_DATA_W     = 128;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    // Job sequencing states of the store unit
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with a combinational head read. The head is
// consumed on the same edge it is popped, so the write-side output
// register can capture it directly.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when indices match
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    // Pointer update; reset discards any buffered contents
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Per-entry storage, written only when its slot is the write target
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture incoming word into this slot
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/vector_store_unit.sv
// Writer-side engine for the vector RAM: takes a store job (base, length),
// buffers the incoming vector stream and writes it to sequential addresses,
// one word per clock.
module vector_store_unit
    import vec_store_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] w_addr,
    output logic              write_enable,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_written
);

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] accepted_reg;
    logic [ADDR_W-1:0] issued_reg;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] w_addr_reg;
    logic              we_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              start_accept;
    logic              push;
    logic              pop;
    logic              last_pop;

    // Stop accepting once the job's word count has been taken in, so
    // extra words offered after the job stay with the producer.
    assign start_accept = (state_reg == ST_IDLE) && start;
    assign in_ready     = (state_reg == ST_RUN) && !fifo_full && (accepted_reg < len_reg);
    assign push         = in_valid && in_ready;
    assign pop          = (state_reg == ST_RUN) && !fifo_empty && (issued_reg < len_reg);
    assign last_pop     = pop && ((issued_reg + ADDR_W'(1)) == len_reg);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next state: the final pop moves to DONE on the same edge the last
    // write is registered, so the strobe and DONE coincide.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = (length == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last_pop) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Job parameters and progress counters; issued doubles as words_written
    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg     <= '0;
            len_reg      <= '0;
            accepted_reg <= '0;
            issued_reg   <= '0;
        end else if (start_accept) begin
            base_reg     <= base_addr;
            len_reg      <= length;
            accepted_reg <= '0;
            issued_reg   <= '0;
        end else begin
            if (push) accepted_reg <= accepted_reg + ADDR_W'(1);
            if (pop)  issued_reg   <= issued_reg + ADDR_W'(1);
        end
    end

    // RAM write port register; data and address hold between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg   <= '0;
            w_addr_reg <= '0;
            we_reg     <= 1'b0;
        end else begin
            we_reg <= pop;
            if (pop) begin
                data_reg   <= fifo_head;
                w_addr_reg <= base_reg + issued_reg;
            end
        end
    end

    assign data          = data_reg;
    assign w_addr        = w_addr_reg;
    assign write_enable  = we_reg;
    assign busy          = (state_reg == ST_RUN);
    assign done          = (state_reg == ST_DONE);
    assign words_written = issued_reg;

endmodule
